// File: rtl/controle_multiciclo_if.sv
// Control/datapath bundle for the multi-cycle RV32I controller: instruction
// fields and status flags in, datapath enables, mux selects and memory
// handshake out.
interface controle_multiciclo_if;
  // Instruction fields and datapath status
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  // Memory handshake and datapath control
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state_o;

  // Controller side
  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, instr_done, illegal, state_o
  );

  // Datapath / memory side
  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, instr_done, illegal, state_o
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle RV32I control FSM: one state per cycle, shared ALU, single
// variable-latency memory port. Outputs are decoded from the current state
// plus the instruction fields, zero and mem_ready.
module controle_multiciclo (
  input logic                  clk,
  input logic                  reset,
  controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrWb   = 4'd12,
    StLui      = 4'd13,
    StTrap     = 4'd14
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  state_e state_q;
  logic   branch_legal;
  logic   branch_taken;
  logic   sub_sra;
  logic [3:0] alu_dec;

  // Only BEQ/BNE are supported; other branch funct3 codes trap.
  assign branch_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
  assign branch_taken = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                        ((bus.funct3 == 3'b001) && !bus.zero);
  assign bus.state_o  = state_q;

  // State register with next-state decode; async reset returns to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch:    if (bus.mem_ready) state_q <= StDecode;
        StDecode: begin
          case (bus.opcode)
            OpLoad, OpStore: state_q <= StMemAdr;
            OpR:             state_q <= StExecR;
            OpI:             state_q <= StExecI;
            OpBranch:        state_q <= StBranch;
            OpJal:           state_q <= StJal;
            OpJalr:          state_q <= StJalr;
            OpLui:           state_q <= StLui;
            default:         state_q <= StTrap;
          endcase
        end
        StMemAdr:   state_q <= (bus.opcode == OpLoad) ? StMemRead : StMemWrite;
        StMemRead:  if (bus.mem_ready) state_q <= StMemWb;
        StMemWb:    state_q <= StFetch;
        StMemWrite: if (bus.mem_ready) state_q <= StFetch;
        StExecR,
        StExecI:    state_q <= StAluWb;
        StAluWb:    state_q <= StFetch;
        StBranch:   state_q <= branch_legal ? StFetch : StTrap;
        StJal:      state_q <= StFetch;
        StJalr:     state_q <= StJalrWb;
        StJalrWb:   state_q <= StFetch;
        StLui:      state_q <= StFetch;
        StTrap:     state_q <= StTrap;
        default:    state_q <= StTrap;
      endcase
    end
  end

  // ALU operation from funct3; funct7[5] selects SUB only for R-type, SRA for both.
  assign sub_sra = bus.funct7[5];
  always_comb begin
    alu_dec = AluAdd;
    unique case (bus.funct3)
      3'b000:  alu_dec = (state_q == StExecR && sub_sra) ? AluSub : AluAdd;
      3'b001:  alu_dec = AluSll;
      3'b010:  alu_dec = AluSlt;
      3'b011:  alu_dec = AluSltu;
      3'b100:  alu_dec = AluXor;
      3'b101:  alu_dec = sub_sra ? AluSra : AluSrl;
      3'b110:  alu_dec = AluOr;
      3'b111:  alu_dec = AluAnd;
      default: alu_dec = AluAdd;
    endcase
  end

  // Output decode; everything held at zero while reset is asserted so that an
  // in-flight memory request is dropped without waiting for a clock edge.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.iord        = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 1'b0;
    bus.reg_write   = 1'b0;
    bus.result_src  = 2'b00;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = AluAnd;
    bus.instr_done  = 1'b0;
    bus.illegal     = 1'b0;
    if (reset) begin
      unique case (state_q)
        StFetch: begin
          bus.mem_req     = 1'b1;
          bus.alu_src_a   = 2'b00;
          bus.alu_src_b   = 2'b10;
          bus.alu_control = AluAdd;
          bus.ir_write    = bus.mem_ready;
          bus.pc_write    = bus.mem_ready;
        end
        StDecode: begin
          bus.alu_src_a   = 2'b01;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = AluAdd;
        end
        StMemAdr: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = AluAdd;
        end
        StMemRead: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        StMemWb: begin
          bus.reg_write  = 1'b1;
          bus.result_src = 2'b01;
          bus.instr_done = 1'b1;
        end
        StMemWrite: begin
          bus.mem_req    = 1'b1;
          bus.mem_we     = 1'b1;
          bus.iord       = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        StExecR: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b00;
          bus.alu_control = alu_dec;
        end
        StExecI: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = alu_dec;
        end
        StAluWb: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        StBranch: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b00;
          bus.alu_control = AluSub;
          bus.pc_src      = 1'b1;
          bus.pc_write    = branch_legal && branch_taken;
          bus.instr_done  = branch_legal;
        end
        StJal, StJalrWb: begin
          bus.alu_src_a   = 2'b01;
          bus.alu_src_b   = 2'b10;
          bus.alu_control = AluAdd;
          bus.result_src  = 2'b10;
          bus.reg_write   = 1'b1;
          bus.pc_write    = 1'b1;
          bus.pc_src      = 1'b1;
          bus.instr_done  = 1'b1;
        end
        StJalr: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = AluAdd;
        end
        StLui: begin
          bus.alu_src_a   = 2'b11;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = AluAdd;
          bus.result_src  = 2'b10;
          bus.reg_write   = 1'b1;
          bus.instr_done  = 1'b1;
        end
        StTrap:  bus.illegal = 1'b1;
        default: bus.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle RISC-V (RV32I subset) control FSM that sequences a shared-ALU, single-memory-port datapath. It decodes the instruction register fields and drives all datapath enables and muxes one state per cycle. It also handshakes with a variable-latency unified instruction/data memory. It pairs with the multi-cycle datapath the same way the single-cycle control unit pairs with its datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; forces FSM to FETCH
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- mem_req  out  1  memory access request
- mem_we  out  1  1=write (store), valid with mem_req
- iord  out  1  address select: 0=PC, 1=ALUOut
- ir_write  out  1  latch IR and OldPC
- pc_write  out  1  PC load enable
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
- reg_write  out  1  register file write enable
- result_src  out  2  writeback: 00=ALUOut, 01=MDR, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SRA, 1001 SLTU
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  high in TRAP
- state_o  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRWB 12, LUI 13, TRAP 14.
- Outputs are decoded from state, opcode/funct fields, zero and mem_ready. Unlisted outputs are 0 and unlisted muxes are 00.
- FETCH: mem_req, iord=0, a=PC, b=4, ADD. When mem_ready=1: ir_write, pc_write, pc_src=0, then go to DECODE. Otherwise stay, with no writes.
- DECODE: a=OldPC, b=imm, ADD (branch/JAL target goes to ALUOut). Next state by opcode:
  - 0000011/0100011 go to MEMADR.
  - 0110011 goes to EXECR; 0010011 goes to EXECI.
  - 1100011 goes to BRANCH; 1101111 goes to JAL; 1100111 goes to JALR.
  - 0110111 goes to LUI.
  - Anything else goes to TRAP.
- MEMADR: a=rs1, b=imm, ADD. Load goes to MEMREAD; store goes to MEMWRITE.
- MEMREAD: mem_req, iord=1. When mem_ready, go to MEMWB.
- MEMWB: reg_write, result_src=01, instr_done, then go to FETCH.
- MEMWRITE: mem_req, mem_we, iord=1. When mem_ready: instr_done, then go to FETCH.
- EXECR: a=rs1, b=rs2. Then go to ALUWB.
- EXECI: a=rs1, b=imm. Then go to ALUWB.
- ALUWB: reg_write, result_src=00, instr_done, then go to FETCH.
- ALU decode for EXECR/EXECI, by funct3:
  - 000: ADD, or SUB when R-type and funct7[5]=1.
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1.
  - 110: OR; 111: AND.
- BRANCH: a=rs1, b=rs2, SUB, pc_src=1.
  - pc_write = (funct3=000 & zero) | (funct3=001 & ~zero).
  - Then instr_done and go to FETCH.
  - Any other funct3 goes to TRAP without pc_write.
- JAL: a=OldPC, b=4, ADD, result_src=10, reg_write, pc_write, pc_src=1, instr_done, then go to FETCH.
- JALR: a=rs1, b=imm, ADD. Then go to JALRWB.
- JALRWB: a=OldPC, b=4, ADD, result_src=10, reg_write, pc_write, pc_src=1, instr_done, then go to FETCH.
- LUI: a=zero, b=imm, ADD, result_src=10, reg_write, instr_done, then go to FETCH.
- TRAP: illegal=1, all enables 0. Stays in TRAP until reset.

## Timing
- reset low (asynchronous): state goes to FETCH immediately. While reset is low, all enables, mem_req and instr_done are forced to 0. In the first clk after release, FETCH asserts mem_req.
- Reset mid-access: mem_req drops asynchronously, and the pending access is abandoned.
- Memory handshake: mem_req, mem_we and iord stay stable from assertion until the cycle mem_ready=1 is sampled. The transfer completes in that cycle. mem_ready while mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory (mem_ready already high):
  - Load: 5.
  - R/I-ALU: 4; store: 4; JALR: 4.
  - Branch: 3; JAL: 3; LUI: 3.
  - Each cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Exactly one instr_done per retired instruction. No instr_done in TRAP.
- ir_write and pc_write never assert in the same cycle except in FETCH.

## Test plan
- R-type ADD (opcode 0110011, funct3 000, funct7 0), zero-wait -> states 0,1,6,8; alu_control 0010 in EXECR; reg_write with result_src=00 in cycle 4; instr_done pulses once.
- SUB plus SRA decode: funct7=0100000, funct3 000 -> 0110; funct3 101 -> 1000. ADDI with funct7[5]=1 -> 0010.
- LW with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD -> total 10 cycles; mem_req and iord held stable throughout; MEMWB has result_src=01.
- BEQ with zero=1 -> pc_write=1, pc_src=1 in BRANCH. BEQ with zero=0 -> pc_write=0. BNE inverse. funct3=100 -> TRAP, illegal=1.
- JALR -> 4 states ending JALRWB with reg_write, pc_write, result_src=10, pc_src=1 in the same cycle. Undefined opcode 0000000 -> TRAP held for 20 cycles, no enables.
- Assert reset low mid-MEMWRITE with mem_req=1 -> mem_req drops without waiting for clk; after release, state_o=0 and mem_req=1 with iord=0.
